freq_meas_sequencer: RTL and testbench
======================================

# freq_meas_sequencer

Measurement sequencer for the frequency meter. On a start request it:
- enables the external settle timer and waits for its done flag;
- opens a gate window of fixed length and counts rising edges of the measured signal;
- latches the count and holds it for the host under a valid/ack handshake.

It owns the settle timer's enable and is the only block that drives it.

## Interface
Parameters:
- CNT_W, 32, width of the edge count and result
- GATE_CYCLES, 50_000_000, gate window length in sysClk cycles (1 s at 50 MHz); must be ≥1

Ports:
- sysClk  in  1  system clock
- sysRst  in  1  reset, asynchronous, active-high
- start  in  1  request a measurement; sampled in IDLE only
- abort  in  1  cancel the measurement in progress
- sigIn  in  1  measured signal, asynchronous to sysClk
- settle_done  in  1  settle timer done flag; level, held while settle_en is high
- settle_en  out  1  settle timer enable
- busy  out  1  high in every state except IDLE
- result  out  CNT_W  last latched edge count
- overflow  out  1  last latched count saturated
- result_valid  out  1  result available, high in HOLD
- result_ack  in  1  host consumed result

## Operation
- States: IDLE, SETTLE, GATE, HOLD.
- Reset value of every output and register is 0; state resets to IDLE.
- IDLE: start=1 → SETTLE.
- SETTLE: settle_en=1; settle_done=1 → GATE. On entry to GATE, the edge count and gate counter are cleared to 0.
- GATE: settle_en=0. Each edge pulse seen while in GATE increments the edge count. The gate counter runs 0..GATE_CYCLES-1. On the cycle the gate counter reaches GATE_CYCLES-1:
  - result ← final count, including a pulse present in that same cycle;
  - overflow ← saturation flag;
  - next state HOLD.
- HOLD: result_valid=1; result_ack=1 → IDLE.
- Edge count saturates at 2^CNT_W−1 and does not wrap. The saturation flag is sticky for the current gate.
- abort has the highest priority. From SETTLE, GATE or HOLD the next state is IDLE and result_valid drops. result and overflow keep their last values. abort in IDLE has no effect.
- start outside IDLE is ignored and is not queued.
- abort and result_ack together in HOLD → IDLE; the outcome is identical either way.
- settle_done in any state other than SETTLE is ignored.
- Async reset mid-operation forces IDLE and zeroes every output immediately, without waiting for a clock edge.

## Timing
- start high at edge t (IDLE) → busy=1 and settle_en=1 after edge t.
- settle_done sampled high at edge t → GATE from t, settle_en=0 after t.
- The gate lasts exactly GATE_CYCLES cycles.
- result_valid rises on the edge that ends the last gate cycle.
- result_ack sampled at edge t → result_valid=0 and busy=0 after t.
- sigIn path is a 2-flop synchronizer followed by a registered rising-edge detect. A sigIn rise lands as an edge pulse 3 sysClk edges later.
  - Count accuracy is ±1 edge for arbitrary phase.
  - Maximum countable rate is sysClk/2 with input high and low each ≥1 cycle.
- Synchronizer flops run in every state. Edge pulses outside GATE are discarded.

## Structure
- Package freq_meter_pkg holds:
  - the state enum (IDLE, SETTLE, GATE, HOLD);
  - default constants for CLK_HZ=50_000_000, GATE_CYCLES and CNT_W, shared with the settle timer and display logic.
- Sub-module sig_edge_sync: 2-flop synchronizer plus rising-edge pulse, one-cycle output.
- Gate counter width is $clog2(GATE_CYCLES+1).

## Test plan
All scenarios use GATE_CYCLES=100 and CNT_W=8 unless stated; settle_done is driven 20 cycles after settle_en rises.
- sigIn square wave, period 10 cycles, first rise phase-aligned to the gate start → result=10, overflow=0, result_valid high until ack.
- CNT_W=4, sigIn period 4 cycles (25 edges in the gate) → result=15, overflow=1.
- abort pulsed on gate cycle 50, previous result=7 → IDLE next cycle, busy=0, result_valid stays 0, result stays 7.
- start pulsed during SETTLE and during HOLD → ignored. After ack, start is accepted; a second measurement with sigIn held high gives result=0.
- sysRst asserted mid-GATE → settle_en, busy, result, overflow and result_valid go 0 immediately. After release, start gives a normal measurement.
- result_ack held high continuously → HOLD lasts exactly one cycle and result_valid is a one-cycle pulse.

Source files
------------

// File: rtl/freq_meas_sequencer_pkg.sv
// Shared frequency-meter definitions: sequencer state encoding and default
// sizing constants used by the sequencer, settle timer and display logic.
package freq_meter_pkg;

  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned DEF_GATE_CYCLES = 50_000_000;  // 1 s gate at CLK_HZ
  localparam int unsigned DEF_CNT_W       = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    HOLD   = 2'd3
  } meas_state_e;

endpackage

// File: rtl/freq_meas_sequencer_sig_edge_sync.sv
// Brings the asynchronous measured signal into the sysClk domain and emits a
// one-cycle pulse for each rising edge. A rise appears as a pulse three edges
// after it is first sampled.
module sig_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pulse_q;

  // Two-flop synchronizer, delayed copy and registered rise detect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/freq_meas_sequencer.sv
// Frequency meter measurement sequencer: settle, fixed gate window edge
// count with saturation, then hold the result under a valid/ack handshake.
module freq_meas_sequencer
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic             sysClk,
  input  logic             sysRst,
  input  logic             start,
  input  logic             abort,
  input  logic             sigIn,
  input  logic             settle_done,
  output logic             settle_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ack
);

  localparam int unsigned      GCW       = $clog2(GATE_CYCLES + 1);
  localparam logic [GCW-1:0]   GATE_LAST = GCW'(GATE_CYCLES - 1);

  meas_state_e      state_q;
  logic [GCW-1:0]   gate_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [CNT_W-1:0] edge_cnt_d;
  logic             sat_q;
  logic             sat_d;
  logic [CNT_W-1:0] result_q;
  logic             overflow_q;
  logic             settle_en_q;
  logic             busy_q;
  logic             valid_q;
  logic             edge_pulse;

  sig_edge_sync u_sync (
    .clk_i   (sysClk),
    .rst_i   (sysRst),
    .sig_i   (sigIn),
    .pulse_o (edge_pulse)
  );

  // Saturating edge count including the pulse present this cycle
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    if (edge_pulse) begin
      if (edge_cnt_q == '1) begin
        sat_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

  // Sequencer FSM with registered outputs; abort outranks every other input
  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      state_q     <= IDLE;
      gate_cnt_q  <= '0;
      edge_cnt_q  <= '0;
      sat_q       <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      settle_en_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= SETTLE;
            settle_en_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q     <= IDLE;
            settle_en_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (settle_done) begin
            state_q     <= GATE;
            settle_en_q <= 1'b0;
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            sat_q       <= 1'b0;
          end
        end
        GATE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            if (gate_cnt_q == GATE_LAST) begin
              // latch from the _d terms so a pulse in the final cycle counts
              result_q   <= edge_cnt_d;
              overflow_q <= sat_d;
              valid_q    <= 1'b1;
              state_q    <= HOLD;
            end else begin
              gate_cnt_q <= gate_cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (abort || result_ack) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          settle_en_q <= 1'b0;
          busy_q      <= 1'b0;
          valid_q     <= 1'b0;
        end
      endcase
    end
  end

  assign settle_en    = settle_en_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign overflow     = overflow_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Bench for freq_meas_sequencer: two instances (CNT_W=8 and CNT_W=4) share
// all inputs; expected counts come from a sigIn history and the rule that a
// rise sampled at edge m is counted when m lies in [T-2, T+G-3], T being the
// edge on which settle_done is taken.
module tb_freq_meas_sequencer;

  localparam int unsigned G = 100;

  logic       sysClk = 1'b0;
  logic       sysRst;
  logic       start;
  logic       abort;
  logic       sigIn;
  logic       settle_done;
  logic       result_ack;

  logic       se_a, busy_a, ov_a, val_a;
  logic [7:0] res_a;
  logic       se_b, busy_b, ov_b, val_b;
  logic [3:0] res_b;

  int n_chk  = 0;
  int n_fail = 0;
  int ecount = 0;
  bit hist[int];

  int pat_p   = 5;
  int pat_hi  = 0;
  int pat_ref = 0;
  bit pat_rnd = 1'b0;

  typedef struct {
    int   p;
    int   hi;
    logic [7:0] e8;
    logic       o8;
    logic [3:0] e4;
    logic       o4;
  } vec_t;

  freq_meas_sequencer #(.CNT_W(8), .GATE_CYCLES(G)) dut_a (
    .sysClk(sysClk), .sysRst(sysRst), .start(start), .abort(abort),
    .sigIn(sigIn), .settle_done(settle_done), .settle_en(se_a),
    .busy(busy_a), .result(res_a), .overflow(ov_a),
    .result_valid(val_a), .result_ack(result_ack)
  );

  freq_meas_sequencer #(.CNT_W(4), .GATE_CYCLES(G)) dut_b (
    .sysClk(sysClk), .sysRst(sysRst), .start(start), .abort(abort),
    .sigIn(sigIn), .settle_done(settle_done), .settle_en(se_b),
    .busy(busy_b), .result(res_b), .overflow(ov_b),
    .result_valid(val_b), .result_ack(result_ack)
  );

  always #5 sysClk = ~sysClk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit gen_sig(input int n);
    int r;
    if (pat_rnd) return 1'($urandom_range(0, 1));
    r = (n - pat_ref) % pat_p;
    if (r < 0) r += pat_p;
    return (r < pat_hi);
  endfunction

  // Apply inputs for one cycle, record sigIn, advance past the edge
  task automatic cyc(input bit s, input bit a, input bit d, input bit k);
    start       = s;
    abort       = a;
    settle_done = d;
    result_ack  = k;
    sigIn       = gen_sig(ecount);
    hist[ecount] = sigIn;
    @(posedge sysClk);
    ecount++;
    #1;
  endtask

  function automatic void model(input int T, input int w, output int r, output bit ov);
    int c;
    int mx;
    c = 0;
    for (int m = T - 2; m <= T + int'(G) - 3; m++)
      if (hist[m] && !hist[m-1]) c++;
    mx = (1 << w) - 1;
    ov = (c > mx);
    r  = ov ? mx : c;
  endfunction

  task automatic measure(input int p, input int hi, input bit rnd, input int abort_at,
                         input int ack_wait, input bit poke, input bit ack_hold,
                         input bit sd_noise, input bit ack_abort);
    int T;
    int r8, r4;
    bit o8, o4;
    logic [7:0] prev8;
    logic [3:0] prev4;
    logic pov8, pov4;
    T = ecount + 21;
    pat_p = p; pat_hi = hi; pat_ref = T - 2; pat_rnd = rnd;
    prev8 = res_a; prev4 = res_b; pov8 = ov_a; pov4 = ov_b;
    cyc(1, 0, 0, 0);
    chk("start_busy_settle_en", {busy_a, se_a, busy_b, se_b}, 4'hF);
    for (int i = 0; i < 20; i++) cyc(poke && i == 5, 0, 0, 0);
    chk("settle_hold", {busy_a, se_a, val_a}, 3'b110);
    cyc(0, 0, 1, ack_hold);
    chk("gate_entry", {busy_a, se_a, se_b}, 3'b100);
    for (int i = 0; i < int'(G); i++) begin
      if (i == abort_at) begin
        cyc(0, 1, sd_noise ? 1'($urandom_range(0, 1)) : 1'b0, ack_hold);
        chk("abort_busy_valid", {busy_a, val_a, se_a, busy_b, val_b}, 5'b0);
        chk("abort_result_a", {ov_a, res_a}, {pov8, prev8});
        chk("abort_result_b", {ov_b, res_b}, {pov4, prev4});
        cyc(0, 0, 0, 0);
        chk("abort_stays_idle", {busy_a, val_a}, 2'b00);
        return;
      end
      cyc(0, 0, sd_noise ? 1'($urandom_range(0, 1)) : 1'b0, ack_hold);
      if (i == int'(G) - 2) chk("gate_last_cycle_valid", {val_a, busy_a}, 2'b01);
    end
    model(T, 8, r8, o8);
    model(T, 4, r4, o4);
    chk("hold_valid", {val_a, val_b, busy_a}, 3'b111);
    chk("result_w8", res_a, r8);
    chk("overflow_w8", ov_a, o8);
    chk("result_w4", res_b, r4);
    chk("overflow_w4", ov_b, o4);
    for (int i = 0; i < ack_wait; i++) begin
      cyc(poke && i == 0, 0, 0, 0);
      chk("hold_wait_valid", {val_a, busy_a}, 2'b11);
    end
    cyc(0, ack_abort, 0, 1);
    chk("ack_release", {val_a, busy_a, val_b, busy_b}, 4'b0);
    chk("ack_keeps_result", res_a, r8);
    if (poke) begin
      cyc(0, 0, 0, 0);
      chk("start_not_queued", busy_a, 0);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int T;
    vecs.push_back('{p: 10, hi: 5, e8: 8'd10, o8: 1'b0, e4: 4'd10, o4: 1'b0});
    vecs.push_back('{p: 4,  hi: 2, e8: 8'd25, o8: 1'b0, e4: 4'd15, o4: 1'b1});
    vecs.push_back('{p: 2,  hi: 1, e8: 8'd50, o8: 1'b0, e4: 4'd15, o4: 1'b1});
    vecs.push_back('{p: 8,  hi: 4, e8: 8'd13, o8: 1'b0, e4: 4'd13, o4: 1'b0});
    vecs.push_back('{p: 6,  hi: 3, e8: 8'd17, o8: 1'b0, e4: 4'd15, o4: 1'b1});
    vecs.push_back('{p: 3,  hi: 1, e8: 8'd34, o8: 1'b0, e4: 4'd15, o4: 1'b1});
    vecs.push_back('{p: 5,  hi: 5, e8: 8'd0,  o8: 1'b0, e4: 4'd0,  o4: 1'b0});
    vecs.push_back('{p: 5,  hi: 0, e8: 8'd0,  o8: 1'b0, e4: 4'd0,  o4: 1'b0});
    vecs.push_back('{p: 15, hi: 7, e8: 8'd7,  o8: 1'b0, e4: 4'd7,  o4: 1'b0});

    sysRst = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);
    chk("reset_outputs_a", {se_a, busy_a, res_a, ov_a, val_a}, 0);
    chk("reset_outputs_b", {se_b, busy_b, res_b, ov_b, val_b}, 0);
    sysRst = 1'b0;
    cyc(0, 1, 1, 1);
    chk("idle_ignores_abort_done_ack", {busy_a, se_a, val_a}, 3'b000);

    foreach (vecs[i]) begin
      measure(vecs[i].p, vecs[i].hi, 1'b0, -1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("table%0d_w8", i), {ov_a, res_a}, {vecs[i].o8, vecs[i].e8});
      chk($sformatf("table%0d_w4", i), {ov_b, res_b}, {vecs[i].o4, vecs[i].e4});
    end

    // abort on gate cycle 50 with previous result 7
    measure(10, 5, 1'b0, 50, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_kept_7", res_a, 8'd7);

    // start pokes in SETTLE and HOLD are ignored; then held-high gives 0
    measure(4, 2, 1'b0, -1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    measure(5, 5, 1'b0, -1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("held_high_zero", {ov_a, res_a}, 9'd0);

    // result_ack held throughout: HOLD lasts one cycle
    measure(10, 5, 1'b0, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 1);
    chk("ack_held_single_pulse", {val_a, busy_a}, 2'b00);

    // asynchronous reset in the middle of GATE
    T = ecount + 21;
    pat_p = 10; pat_hi = 5; pat_ref = T - 2; pat_rnd = 1'b0;
    cyc(1, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (30) cyc(0, 0, 0, 0);
    chk("pre_reset_busy", {busy_a, res_a}, {1'b1, 8'd10});
    #2 sysRst = 1'b1;
    #1;
    chk("async_reset_a", {se_a, busy_a, res_a, ov_a, val_a}, 0);
    chk("async_reset_b", {se_b, busy_b, res_b, ov_b, val_b}, 0);
    repeat (2) cyc(0, 0, 0, 0);
    sysRst = 1'b0;
    cyc(0, 0, 0, 0);
    measure(10, 5, 1'b0, -1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_result", res_a, 8'd10);

    // randomized sigIn, settle_done noise, aborts and ack timing
    for (int n = 0; n < 10; n++) begin
      measure(1, 0, 1'b1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, G - 1)) : -1,
              int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1,
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
